// File: rtl/accelerator_standard_fnn_output_collector.sv
// Captures one hidden-output vector from the standard FNN accelerator, flags protocol errors, and replays the vector on request.
// Optional running signature output: define ACCELERATOR_STANDARD_FNN_OUTPUT_COLLECTOR_SIGNATURE_EN.
//
// state     | meaning
// S_IDLE    | waiting for START after reset
// S_CAPTURE | storing H_OUT strobes until size reached or READY
// S_DONE    | capture finished, buffer readable, START re-arms
module accelerator_standard_fnn_output_collector #(
    parameter int DATA_SIZE = 64,
    parameter int L         = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ACCELERATOR_STANDARD_FNN_START,
    input  logic                 ACCELERATOR_STANDARD_FNN_READY,
    input  logic [DATA_SIZE-1:0] ACCELERATOR_STANDARD_FNN_SIZE_L_IN,
    input  logic                 ACCELERATOR_STANDARD_FNN_H_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] ACCELERATOR_STANDARD_FNN_H_OUT,
    input  logic                 COLLECTOR_RD_ENABLE,
    output logic [DATA_SIZE-1:0] COLLECTOR_RD_DATA,
    output logic                 COLLECTOR_RD_VALID,
    output logic [DATA_SIZE-1:0] COLLECTOR_COUNT,
    output logic                 COLLECTOR_DONE,
    output logic                 COLLECTOR_SIZE_ERROR,
    output logic                 COLLECTOR_SHORT_ERROR,
    output logic                 COLLECTOR_STRAY_ERROR
`ifdef ACCELERATOR_STANDARD_FNN_OUTPUT_COLLECTOR_SIGNATURE_EN
    ,
    output logic [DATA_SIZE-1:0] COLLECTOR_SIGNATURE
`endif
);

    localparam int AW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_SIZE-1:0] mem [L];
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_inc;
    logic [CW-1:0]        size_q;
    logic [CW-1:0]        size_arm;
    logic [CW-1:0]        rd_ptr;
    logic                 arm;
    logic                 wr;
    logic                 rd;
    logic                 oversize;
    logic                 short_hit;

    always_comb begin
        arm       = (state != S_CAPTURE) && ACCELERATOR_STANDARD_FNN_START;
        wr        = (state == S_CAPTURE) && ACCELERATOR_STANDARD_FNN_H_OUT_ENABLE;
        rd        = (state == S_DONE) && COLLECTOR_RD_ENABLE && (rd_ptr < count);
        count_inc = count + CW'(wr);
        oversize  = ACCELERATOR_STANDARD_FNN_SIZE_L_IN > DATA_SIZE'(L);
        size_arm  = oversize ? CW'(L) : CW'(ACCELERATOR_STANDARD_FNN_SIZE_L_IN);
        // A final element coinciding with READY completes the vector, so compare after the write.
        short_hit = (state == S_CAPTURE) && ACCELERATOR_STANDARD_FNN_READY && (count_inc != size_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (ACCELERATOR_STANDARD_FNN_START) begin
                    state_nxt = (ACCELERATOR_STANDARD_FNN_SIZE_L_IN == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if ((count_inc == size_q) || ACCELERATOR_STANDARD_FNN_READY) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        COLLECTOR_DONE  = (state == S_DONE);
        COLLECTOR_COUNT = DATA_SIZE'(count);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count                 <= '0;
            size_q                <= '0;
            rd_ptr                <= '0;
            COLLECTOR_RD_DATA     <= '0;
            COLLECTOR_RD_VALID    <= 1'b0;
            COLLECTOR_SIZE_ERROR  <= 1'b0;
            COLLECTOR_SHORT_ERROR <= 1'b0;
            COLLECTOR_STRAY_ERROR <= 1'b0;
        end else begin
            COLLECTOR_RD_VALID <= rd;
            if (rd) begin
                COLLECTOR_RD_DATA <= mem[rd_ptr[AW-1:0]];
                rd_ptr            <= rd_ptr + CW'(1);
            end
            if (wr) begin
                count <= count_inc;
            end
            if (ACCELERATOR_STANDARD_FNN_H_OUT_ENABLE && (state != S_CAPTURE)) begin
                COLLECTOR_STRAY_ERROR <= 1'b1;
            end
            if (short_hit) begin
                COLLECTOR_SHORT_ERROR <= 1'b1;
            end
            if (arm) begin
                size_q                <= size_arm;
                COLLECTOR_SIZE_ERROR  <= oversize;
                count                 <= '0;
                rd_ptr                <= '0;
                COLLECTOR_SHORT_ERROR <= 1'b0;
            end
        end
    end

    // Write pointer is the element count itself; buffer needs no reset.
    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[count[AW-1:0]] <= ACCELERATOR_STANDARD_FNN_H_OUT;
        end
    end

`ifdef ACCELERATOR_STANDARD_FNN_OUTPUT_COLLECTOR_SIGNATURE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COLLECTOR_SIGNATURE <= '0;
        end else if (arm) begin
            COLLECTOR_SIGNATURE <= '0;
        end else if (wr) begin
            COLLECTOR_SIGNATURE <= {COLLECTOR_SIGNATURE[DATA_SIZE-2:0], COLLECTOR_SIGNATURE[DATA_SIZE-1]}
                                   ^ ACCELERATOR_STANDARD_FNN_H_OUT;
        end
    end
`endif

endmodule

// File: doc/accelerator_standard_fnn_output_collector.md
Name: accelerator_standard_fnn_output_collector

Overview:
- Bench-side consumer for the standard FNN accelerator's hidden-output stream.
- Sits on the DUT's H_OUT / H_OUT_ENABLE / READY outputs, opposite the stimulus generator that drives START and the input vectors.
- Captures one vector of SIZE_L elements into an internal buffer, flags protocol errors, then lets the bench read the vector back in order.

Parameters:
DATA_SIZE, 64, width of each H element
L, 64, buffer depth (maximum vector length); address width is clog2(L), minimum 1

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  asynchronous, active-high reset
ACCELERATOR_STANDARD_FNN_START  input  1  arm pulse, same pulse that is driven to the DUT
ACCELERATOR_STANDARD_FNN_READY  input  1  DUT completion strobe
ACCELERATOR_STANDARD_FNN_SIZE_L_IN  input  DATA_SIZE  expected element count
ACCELERATOR_STANDARD_FNN_H_OUT_ENABLE  input  1  element strobe from DUT
ACCELERATOR_STANDARD_FNN_H_OUT  input  DATA_SIZE  element data
COLLECTOR_RD_ENABLE  input  1  bench read request
COLLECTOR_RD_DATA  output  DATA_SIZE  read data
COLLECTOR_RD_VALID  output  1  RD_DATA valid, one-cycle pulse
COLLECTOR_COUNT  output  DATA_SIZE  elements captured
COLLECTOR_DONE  output  1  capture finished
COLLECTOR_SIZE_ERROR  output  1  SIZE_L_IN > L; size clamped to L
COLLECTOR_SHORT_ERROR  output  1  READY arrived before SIZE elements
COLLECTOR_STRAY_ERROR  output  1  H_OUT_ENABLE while not capturing

Behaviour:
- Reset:
  - Asynchronous reset, active-high.
  - All outputs 0, FSM in IDLE, pointers and count 0.
  - Buffer contents are don't-care.
  - Reset mid-capture aborts immediately; no partial DONE.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - START=1 latches size = min(SIZE_L_IN, L).
  - SIZE_ERROR is set if SIZE_L_IN > L.
  - COUNT, wr_ptr, rd_ptr and SHORT_ERROR are cleared.
  - Next state is CAPTURE, or DONE if SIZE_L_IN == 0.
- CAPTURE:
  - H_OUT_ENABLE=1 writes H_OUT to buffer[wr_ptr], then increments wr_ptr and COUNT.
  - When the write makes COUNT == size, go to DONE next cycle.
  - READY=1 with COUNT < size (after any same-cycle write): set SHORT_ERROR and go to DONE.
  - If the final element and READY arrive in the same cycle, the element is captured and no error is raised.
  - START is ignored in CAPTURE.
- DONE:
  - DONE=1.
  - RD_ENABLE=1 with rd_ptr < COUNT: RD_DATA = buffer[rd_ptr] and RD_VALID=1 on the next cycle; rd_ptr increments.
  - RD_ENABLE=1 with rd_ptr == COUNT: RD_VALID stays 0 and RD_DATA holds its last value.
  - START=1 behaves as in IDLE (re-arm); DONE drops the next cycle.
- Stray strobes: H_OUT_ENABLE=1 in IDLE or DONE sets STRAY_ERROR and the data is not stored. This includes the cycle in which START is sampled, because capture begins the following cycle.
- Sticky error flags:
  - STRAY_ERROR clears only on RST.
  - SIZE_ERROR and SHORT_ERROR are re-evaluated on each arm.
- Arithmetic: COUNT is zero-extended to DATA_SIZE and never exceeds L. Element data is stored unmodified.
- Latency: write takes effect at the strobe edge; read data appears 1 cycle after RD_ENABLE. Back-to-back strobes and reads are supported every cycle.

Optional Feature:
- Macro: ACCELERATOR_STANDARD_FNN_OUTPUT_COLLECTOR_SIGNATURE_EN.
- Defined:
  - Adds output COLLECTOR_SIGNATURE [DATA_SIZE-1:0].
  - Cleared on arm.
  - On each captured element: sig = {sig[DATA_SIZE-2:0], sig[DATA_SIZE-1]} ^ H_OUT.
  - Stray strobes do not update the signature.
  - The value is stable while in DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Nominal capture: SIZE_L_IN=4, START, strobes 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> DONE one cycle after the 4th strobe, COUNT=4, no errors; 5 reads -> RD_VALID on 4 cycles returning 0x11, 0x22, 0x33, 0x44 in order, 5th read gives RD_VALID=0.
- Early READY: SIZE_L_IN=3, two strobes, then READY alone -> SHORT_ERROR=1, DONE=1, COUNT=2. Repeat with SIZE_L_IN=2 and READY coincident with the 2nd strobe -> SHORT_ERROR=0, COUNT=2.
- Oversize and zero size:
  - L=8, SIZE_L_IN=10 -> SIZE_ERROR=1; DONE after 8 strobes; a 9th strobe sets STRAY_ERROR.
  - SIZE_L_IN=0 -> DONE one cycle after START, COUNT=0.
- Stray and simultaneous events: strobe in IDLE, strobe in the same cycle as START, START during CAPTURE -> STRAY_ERROR=1, neither stray value is stored, capture proceeds normally.
- Reset mid-capture: SIZE_L_IN=4, 2 strobes, RST pulse -> all outputs 0 immediately; a fresh START with SIZE_L_IN=1 and one strobe 0xAB -> DONE, read returns 0xAB.
- Signature (macro defined), DATA_SIZE=8: strobes 0x01, 0x02 -> after the first strobe signature is 0x01; after the second, (0x01 rotated = 0x02) ^ 0x02 = 0x00.
